blockade_loader: RTL

Download and boot sequencer between the MiSTer ioctl interface and the `blockade` core. Turns the ioctl byte stream into single-cycle ROM writes on the core's `dn_*` port, paced by `ioctl_wait`. Latches the game-mode selection from a config stream and holds the core in reset during download plus a fixed settle window afterwards. Replaces the ad-hoc `reset || ioctl_download` gating and the free `game_mode` register at the top level.

---
 rtl/blockade_pkg.sv | 21 ++
 rtl/blockade_loader_if.sv | 35 +++
 rtl/blockade_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/blockade_pkg.sv
// blockade_pkg: shared constants and types for the blockade download/boot path.
//   GAME_*   : game-mode codes driven onto the core's game_mode input
//   IDX_*    : ioctl_index values recognised by the loader
//   loader_state_e : boot sequencer states
package blockade_pkg;

    localparam logic [1:0] GAME_BLOCKADE = 2'd0;
    localparam logic [1:0] GAME_COMOTION = 2'd1;
    localparam logic [1:0] GAME_HUSTLE   = 2'd2;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_CFG = 8'd1;

    typedef enum logic [1:0] {
        StHold = 2'd0,
        StRun  = 2'd1,
        StLoad = 2'd2,
        StGap  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/blockade_loader_if.sv
// blockade_loader_if: ioctl download stream plus the core-side ROM write and
// boot control signals.
//   ioctl_download/wr/addr/dout/index : HPS -> loader
//   ioctl_wait                        : loader -> HPS back-pressure
//   core_reset, game_mode             : loader -> core boot control
//   dn_addr/dn_data/dn_wr             : loader -> core ROM write port
//   load_error                        : sticky download error flag
// Modports: master = HPS/core side, slave = loader.
interface blockade_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;

    logic        core_reset;
    logic [1:0]  game_mode;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        load_error;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_wait, core_reset, game_mode, dn_addr, dn_data, dn_wr, load_error
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_wait, core_reset, game_mode, dn_addr, dn_data, dn_wr, load_error
    );

endinterface

// File: rtl/blockade_loader.sv
// blockade_loader: download and boot sequencer between the MiSTer ioctl stream
// and the blockade core.
//   clk_sys  : system clock, all state on its rising edge
//   reset_n  : synchronous active-low reset
//   io_bus   : blockade_loader_if.slave (ioctl stream in, ROM writes and boot
//              control out)
// ROM bytes become one-cycle dn_wr pulses, each followed by WR_GAP cycles of
// ioctl_wait. The core is held in reset while downloading and for RESET_HOLD
// cycles after reset or the end of a download. Every output is registered.
module blockade_loader
    import blockade_pkg::*;
#(
    parameter int unsigned ROM_SIZE   = 16384,
    parameter int unsigned WR_GAP     = 2,
    parameter int unsigned RESET_HOLD = 64
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    blockade_loader_if.slave   io_bus
);

    localparam logic [3:0]  GAP_LAST  = 4'(WR_GAP - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);

    loader_state_e r_state, w_state;
    logic [15:0]   r_hold_cnt, w_hold_cnt;
    logic [3:0]    r_gap_cnt, w_gap_cnt;
    logic [13:0]   r_dn_addr, w_dn_addr;
    logic [7:0]    r_dn_data, w_dn_data;
    logic          r_dn_wr, w_dn_wr;
    logic          r_wait, w_wait;
    logic          r_core_reset, w_core_reset;
    logic [1:0]    r_game_mode, w_game_mode;
    logic          r_load_error, w_load_error;

    logic          w_rom_in_range;
    logic          w_cfg_byte0;

    // Full 25-bit compare so high address bits can never alias into the ROM.
    assign w_rom_in_range = 32'(io_bus.ioctl_addr) < ROM_SIZE;
    assign w_cfg_byte0    = (io_bus.ioctl_addr == 25'd0);

    always_comb begin
        w_state      = r_state;
        w_hold_cnt   = r_hold_cnt;
        w_gap_cnt    = r_gap_cnt;
        w_dn_addr    = r_dn_addr;
        w_dn_data    = r_dn_data;
        w_dn_wr      = 1'b0;
        w_game_mode  = r_game_mode;
        w_load_error = r_load_error;

        unique case (r_state)
            StHold: begin
                // A new download wins over the settle counter expiring.
                if (io_bus.ioctl_download) begin
                    w_state      = StLoad;
                    w_hold_cnt   = 16'd0;
                    w_load_error = 1'b0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state    = StRun;
                    w_hold_cnt = 16'd0;
                end else begin
                    w_hold_cnt = r_hold_cnt + 16'd1;
                end
            end

            StRun: begin
                if (io_bus.ioctl_download) begin
                    w_state      = StLoad;
                    w_load_error = 1'b0;
                end
            end

            StLoad: begin
                // A write is honoured even on the edge where download drops.
                if (io_bus.ioctl_wr) begin
                    if (io_bus.ioctl_index == IDX_ROM) begin
                        if (w_rom_in_range) begin
                            w_dn_addr = io_bus.ioctl_addr[13:0];
                            w_dn_data = io_bus.ioctl_dout;
                            w_dn_wr   = 1'b1;
                            w_gap_cnt = GAP_LAST;
                            w_state   = StGap;
                        end else begin
                            w_load_error = 1'b1;
                        end
                    end else if (io_bus.ioctl_index == IDX_CFG && w_cfg_byte0) begin
                        if (io_bus.ioctl_dout[1:0] == 2'd3) begin
                            w_load_error = 1'b1;
                        end else begin
                            w_game_mode = io_bus.ioctl_dout[1:0];
                        end
                    end
                end else if (!io_bus.ioctl_download) begin
                    w_state    = StHold;
                    w_hold_cnt = 16'd0;
                end
            end

            StGap: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state    = io_bus.ioctl_download ? StLoad : StHold;
                    w_hold_cnt = 16'd0;
                end else begin
                    w_gap_cnt = r_gap_cnt - 4'd1;
                end
            end

            default: begin
                w_state    = StHold;
                w_hold_cnt = 16'd0;
            end
        endcase

        // Wait and core reset are functions of the next state so they come
        // out of flops with no extra cycle of lag.
        w_wait       = (w_state == StGap);
        w_core_reset = (w_state != StRun);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state      <= StHold;
            r_hold_cnt   <= 16'd0;
            r_gap_cnt    <= 4'd0;
            r_dn_addr    <= 14'd0;
            r_dn_data    <= 8'd0;
            r_dn_wr      <= 1'b0;
            r_wait       <= 1'b0;
            r_core_reset <= 1'b1;
            r_game_mode  <= GAME_BLOCKADE;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_hold_cnt   <= w_hold_cnt;
            r_gap_cnt    <= w_gap_cnt;
            r_dn_addr    <= w_dn_addr;
            r_dn_data    <= w_dn_data;
            r_dn_wr      <= w_dn_wr;
            r_wait       <= w_wait;
            r_core_reset <= w_core_reset;
            r_game_mode  <= w_game_mode;
            r_load_error <= w_load_error;
        end
    end

    assign io_bus.ioctl_wait = r_wait;
    assign io_bus.core_reset = r_core_reset;
    assign io_bus.game_mode  = r_game_mode;
    assign io_bus.dn_addr    = r_dn_addr;
    assign io_bus.dn_data    = r_dn_data;
    assign io_bus.dn_wr      = r_dn_wr;
    assign io_bus.load_error = r_load_error;

endmodule
